// File: rtl/seg_pkg.sv
// seg_pkg: shared segment constants and the BCD-to-7-segment table (active-low {g,f,e,d,c,b,a})
package seg_pkg;
  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [9:0][6:0] SEG_TABLE = {7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
                                           7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
endpackage

// File: rtl/seven_seg_scan_if.sv
// seven_seg_scan_if: digit bus from the counter plus the display pins
interface seven_seg_scan_if;
  logic [3:0] d3, d2, d1, d0;
  logic minus_flag;
  logic blank;
  logic [3:0] an;
  logic [6:0] seg;
  logic dp;
  modport master (output d3, d2, d1, d0, minus_flag, blank, input an, seg, dp);
  modport slave (input d3, d2, d1, d0, minus_flag, blank, output an, seg, dp);
endinterface

// File: rtl/seg_decoder.sv
// seg_decoder: BCD code to active-low segment pattern; codes above 9 go dark
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] pat
);
  assign pat = code > 4'd9 ? SEG_BLANK : SEG_TABLE[code];
endmodule

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: 4-digit common-anode display multiplexer with per-frame digit snapshot.
// Optional leading-zero suppression under SEG_LEADING_ZERO_BLANK_EN.
module seven_seg_scan
  import seg_pkg::*;
#(
  parameter int N = 50000,
  parameter int DP_POS = 2
) (
  input logic clk,
  input logic reset,
  seven_seg_scan_if.slave bus
);
  localparam int CW = N > 1 ? $clog2(N) : 1;
  logic [CW-1:0] cnt;
  logic [1:0] sel;
  logic [NUM_DIGITS-1:0][3:0] snap;
  logic snap_minus;
  logic tick;
  logic dark;
  logic [6:0] pat;
  logic [6:0] seg_next;
  assign tick = cnt == CW'(N - 1);
  seg_decoder u_dec (.code(snap[sel]), .pat(pat));
`ifdef SEG_LEADING_ZERO_BLANK_EN
  always_comb
    dark = sel == 2'd3 ? snap[3] == 4'd0 && !snap_minus :
           sel == 2'd2 ? snap[3] == 4'd0 && snap[2] == 4'd0 :
           sel == 2'd1 ? snap[3] == 4'd0 && snap[2] == 4'd0 && snap[1] == 4'd0 : 1'b0;
`else
  always_comb dark = 1'b0;
`endif
  always_comb
    seg_next = sel == 2'd3 && snap_minus ? SEG_MINUS : dark ? SEG_BLANK : pat;
  always_ff @(posedge clk)
    if (reset) begin
      cnt        <= '0;
      sel        <= '0;
      snap       <= '0;
      snap_minus <= 1'b0;
      bus.an     <= 4'hF;
      bus.seg    <= SEG_BLANK;
      bus.dp     <= 1'b1;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) sel <= sel + 2'd1;
      // frame boundary: latch a coherent set of digits for the whole next frame
      if (tick && sel == 2'd3) begin
        snap       <= {bus.d3, bus.d2, bus.d1, bus.d0};
        snap_minus <= bus.minus_flag;
      end
      bus.an  <= bus.blank ? 4'hF : ~(4'b0001 << sel);
      bus.seg <= bus.blank ? SEG_BLANK : seg_next;
      bus.dp  <= bus.blank ? 1'b1 : ~(sel == 2'(DP_POS));
    end
endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: scoreboard bench; a cycle model pushes expected pins each edge, compared 1ns later
module tb_seven_seg_scan;
  logic clk = 1'b0;
  logic reset;
  seven_seg_scan_if bus ();
  seven_seg_scan #(.N(4), .DP_POS(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic dp;
  } out_t;
  out_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int m_cnt, m_sel, m_minus;
  logic [3:0] m_snap [4];
  function automatic logic [6:0] ref_seg(input logic [3:0] c);
    case (c)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction
  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic out_t model_out();
    out_t o;
    logic lz;
    lz = 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (m_sel == 3) lz = m_snap[3] == 0 && m_minus == 0;
    if (m_sel == 2) lz = m_snap[3] == 0 && m_snap[2] == 0;
    if (m_sel == 1) lz = m_snap[3] == 0 && m_snap[2] == 0 && m_snap[1] == 0;
`endif
    if (reset || bus.blank) return '{an: 4'hF, seg: 7'h7F, dp: 1'b1};
    o.an = 4'hF;
    o.an[m_sel] = 1'b0;
    o.seg = (m_sel == 3 && m_minus != 0) ? 7'h3F : lz ? 7'h7F : ref_seg(m_snap[m_sel]);
    o.dp = m_sel != 2;
    return o;
  endfunction
  task automatic step();
    out_t e;
    sb.push_back(model_out());
    @(posedge clk);
    if (reset) begin
      m_cnt = 0; m_sel = 0; m_minus = 0;
      for (int i = 0; i < 4; i++) m_snap[i] = 4'd0;
    end else begin
      if (m_cnt == 3) begin
        if (m_sel == 3) begin
          m_snap[3] = bus.d3; m_snap[2] = bus.d2; m_snap[1] = bus.d1; m_snap[0] = bus.d0;
          m_minus = int'(bus.minus_flag);
        end
        m_sel = (m_sel + 1) % 4;
      end
      m_cnt = (m_cnt + 1) % 4;
    end
    #1;
    if (sb.size() == 0) check("sb_empty", 7'd1, 7'd0);
    else begin
      e = sb.pop_front();
      check("an", {3'b0, bus.an}, {3'b0, e.an});
      check("seg", bus.seg, e.seg);
      check("dp", {6'b0, bus.dp}, {6'b0, e.dp});
    end
  endtask
  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic wait_slot(input logic [3:0] a);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      found = bus.an == a;
    end
    check("wait_an", {6'b0, found}, 7'd1);
  endtask
  task automatic wait_sel(input int s);
    for (int i = 0; i < 40 && m_sel != s; i++) step();
  endtask
  task automatic set_digits(input logic [3:0] a, b, c, d);
    bus.d3 = a; bus.d2 = b; bus.d1 = c; bus.d0 = d;
  endtask
  initial begin
    reset = 1'b1;
    bus.blank = 1'b0;
    bus.minus_flag = 1'b0;
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    step();
    check("rst_an", {3'b0, bus.an}, 7'h0F);
    check("rst_seg", bus.seg, 7'h7F);
    reset = 1'b0;
    steps(40);
    wait_slot(4'hE);
    check("slot0_4", bus.seg, 7'h19);
    wait_slot(4'hB);
    check("dp_slot2", {6'b0, bus.dp}, 7'd0);
    wait_sel(1);
    bus.d0 = 4'd8;
    wait_slot(4'hE);
    check("slot0_8", bus.seg, 7'h00);
    wait_sel(1);
    bus.minus_flag = 1'b1;
    bus.d0 = 4'hB;
    wait_slot(4'hE);
    check("slot0_inv", bus.seg, 7'h7F);
    wait_slot(4'h7);
    check("slot3_minus", bus.seg, 7'h3F);
    bus.minus_flag = 1'b0;
    bus.d0 = 4'd4;
    steps(20);
    wait_sel(1);
    bus.blank = 1'b1;
    step();
    check("blank_an", {3'b0, bus.an}, 7'h0F);
    check("blank_dp", {6'b0, bus.dp}, 7'd1);
    wait_sel(3);
    bus.blank = 1'b0;
    step();
    check("unblank_an", {3'b0, bus.an}, 7'h07);
    for (int i = 0; i < 40 && !(m_sel == 2 && m_cnt == 2); i++) step();
    reset = 1'b1;
    step();
    check("midrst_an", {3'b0, bus.an}, 7'h0F);
    check("midrst_seg", bus.seg, 7'h7F);
    reset = 1'b0;
    step();
    check("restart_an", {3'b0, bus.an}, 7'h0E);
    set_digits(4'd0, 4'd0, 4'd5, 4'd9);
    steps(20);
    wait_slot(4'hE);
    check("slot0_9", bus.seg, 7'h10);
    wait_slot(4'hB);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    check("lz_slot2", bus.seg, 7'h7F);
`else
    check("lz_slot2", bus.seg, 7'h40);
`endif
    wait_slot(4'h7);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    check("lz_slot3", bus.seg, 7'h7F);
`else
    check("lz_slot3", bus.seg, 7'h40);
`endif
    steps(16);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
